// File: rtl/snake_pkg.sv
// snake_pkg: shared game-state encoding, digit indices and 7-segment patterns
package snake_pkg;
   typedef enum logic [1:0] {
      RESTART = 2'b00,
      START   = 2'b01,
      PLAY    = 2'b10,
      DIE     = 2'b11
   } game_status_t;
   typedef logic [1:0] digit_idx_t;
   localparam digit_idx_t DIG_UNITS    = 2'd0;
   localparam digit_idx_t DIG_TENS     = 2'd1;
   localparam digit_idx_t DIG_HUNDREDS = 2'd2;
   localparam logic [6:0] SEG7_0    = 7'b1000000;
   localparam logic [6:0] SEG7_1    = 7'b1111001;
   localparam logic [6:0] SEG7_2    = 7'b0100100;
   localparam logic [6:0] SEG7_3    = 7'b0110000;
   localparam logic [6:0] SEG7_4    = 7'b0011001;
   localparam logic [6:0] SEG7_5    = 7'b0010010;
   localparam logic [6:0] SEG7_6    = 7'b0000010;
   localparam logic [6:0] SEG7_7    = 7'b1111000;
   localparam logic [6:0] SEG7_8    = 7'b0000000;
   localparam logic [6:0] SEG7_9    = 7'b0010000;
   localparam logic [6:0] SEG7_DASH = 7'b0111111;
   localparam logic [6:0] SEG7_OFF  = 7'b1111111;
endpackage

// File: rtl/seg7_score_scan_if.sv
// seg7_score_scan_if: score/status inputs and segment/digit pins of the display scanner
interface seg7_score_scan_if;
   import snake_pkg::*;
   logic [11:0]  bcd_data;
   game_status_t game_status;
   logic [7:0]   seg_n;
   logic [2:0]   dig_n;
   modport master (output bcd_data, game_status, input seg_n, dig_n);
   modport slave (input bcd_data, game_status, output seg_n, dig_n);
endinterface

// File: rtl/seg7_score_scan_bcd_to_seg7.sv
// bcd_to_seg7: one BCD nibble to an active-low g..a pattern, dash for non-decimal codes
module bcd_to_seg7
   import snake_pkg::*;
(
   input  logic [3:0] nib,
   output logic [6:0] seg
);
   // nibble lookup; anything above 9 is shown as a dash
   always_comb begin
      case (nib)
         4'd0:    seg = SEG7_0;
         4'd1:    seg = SEG7_1;
         4'd2:    seg = SEG7_2;
         4'd3:    seg = SEG7_3;
         4'd4:    seg = SEG7_4;
         4'd5:    seg = SEG7_5;
         4'd6:    seg = SEG7_6;
         4'd7:    seg = SEG7_7;
         4'd8:    seg = SEG7_8;
         4'd9:    seg = SEG7_9;
         default: seg = SEG7_DASH;
      endcase
   end
endmodule

// File: rtl/seg7_score_scan.sv
// seg7_score_scan: 3-digit multiplexed common-anode display with frame latch, blanking, dead time and blink
module seg7_score_scan
   import snake_pkg::*;
#(
   parameter int SCAN_DIV     = 50000,
   parameter int DEAD_CYC     = 500,
   parameter int BLINK_FRAMES = 167
)(
   input logic               clk,
   input logic               rst_n,
   seg7_score_scan_if.slave  bus
);
   localparam int CW = $clog2(SCAN_DIV);
   localparam int FW = $clog2(BLINK_FRAMES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
   localparam logic [CW-1:0] CNT_DEAD = CW'(DEAD_CYC);
   localparam logic [FW-1:0] FRM_LAST = FW'(BLINK_FRAMES - 1);

   logic [CW-1:0] cnt;
   digit_idx_t    idx;
   logic [11:0]   shadow;
   logic [FW-1:0] frm;
   logic          dark;
   logic          slot_end, frame_end, in_die, blank;
   logic [3:0]    nib;
   logic [6:0]    pat;
   logic [2:0]    dig_d;
   logic [7:0]    seg_d;

   assign slot_end  = cnt == CNT_LAST;
   assign frame_end = slot_end && idx == DIG_HUNDREDS;
   assign in_die    = bus.game_status == DIE;

   // slot counter, digit rotation and the once-per-frame score capture
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt    <= '0;
         idx    <= DIG_UNITS;
         shadow <= '0;
      end else begin
         cnt <= slot_end ? '0 : cnt + 1'b1;
         if (slot_end)
            idx <= idx == DIG_HUNDREDS ? DIG_UNITS : idx + 1'b1;
         if (frame_end)
            shadow <= bus.bcd_data;
      end
   end

   // game-over blink: leaving DIE clears the phase, which beats a coincident frame count
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frm  <= '0;
         dark <= 1'b0;
      end else if (!in_die) begin
         frm  <= '0;
         dark <= 1'b0;
      end else if (frame_end) begin
         frm <= frm == FRM_LAST ? '0 : frm + 1'b1;
         if (frm == FRM_LAST)
            dark <= ~dark;
      end
   end

   bcd_to_seg7 u_dec (.nib(nib), .seg(pat));

   // digit select plus the three reasons a slot stays dark: dead time, blink, leading zero
   always_comb begin
      nib   = idx == DIG_HUNDREDS ? shadow[11:8] : idx == DIG_TENS ? shadow[7:4] : shadow[3:0];
      blank = cnt < CNT_DEAD || dark
              || (idx == DIG_HUNDREDS && shadow[11:8] == 4'd0)
              || (idx == DIG_TENS && shadow[11:4] == 8'd0);
      dig_d = blank ? 3'b111 : ~(3'b001 << idx);
      seg_d = blank ? {1'b1, SEG7_OFF} : {1'b1, pat};
   end

   // registered pin drivers, all off while in reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.dig_n <= 3'b111;
         bus.seg_n <= 8'hFF;
      end else begin
         bus.dig_n <= dig_d;
         bus.seg_n <= seg_d;
      end
   end
endmodule

// File: tb/tb_seg7_score_scan.sv
// tb_seg7_score_scan: directed and random stimulus scored against a cycle-count reference model
module tb_seg7_score_scan;
   import snake_pkg::*;
   localparam int SD = 8;
   localparam int DC = 2;
   localparam int BF = 2;
   localparam int FRAME = 3 * SD;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   errors = 0;
   int   checks = 0;

   seg7_score_scan_if bus ();

   seg7_score_scan #(.SCAN_DIV(SD), .DEAD_CYC(DC), .BLINK_FRAMES(BF)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [6:0] seg_tab(input logic [3:0] n);
      logic [6:0] tab [10];
      tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
              7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
      return n > 4'd9 ? 7'b0111111 : tab[n];
   endfunction

   // expected {dig_n, seg_n} for cycle t after reset release, given the latched score and DIE frame count
   function automatic logic [10:0] model_out(input int t, input logic [11:0] sh, input int frames);
      int pos;
      int d;
      bit blank;
      pos = t % SD;
      d = (t / SD) % 3;
      blank = pos < DC || ((frames / BF) % 2 == 1)
              || (d == 2 && sh[11:8] == 4'd0) || (d == 1 && sh[11:4] == 8'd0);
      return blank ? {3'b111, 8'hFF} : {3'b111 ^ (3'b001 << d), 1'b1, seg_tab(sh[d*4 +: 4])};
   endfunction

   int          m_t;
   int          m_frames;
   logic [11:0] m_sh;
   logic [2:0]  exp_dig;
   logic [7:0]  exp_seg;

   // reference model: everything derived from the cycle count since reset release
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_t <= 0;
         m_sh <= '0;
         m_frames <= 0;
         {exp_dig, exp_seg} <= {3'b111, 8'hFF};
      end else begin
         {exp_dig, exp_seg} <= model_out(m_t, m_sh, m_frames);
         m_t <= m_t + 1;
         if (m_t % FRAME == FRAME - 1)
            m_sh <= bus.bcd_data;
         m_frames <= bus.game_status != DIE ? 0 : (m_t % FRAME == FRAME - 1) ? m_frames + 1 : m_frames;
      end
   end

   // scoreboard on the falling edge
   always @(negedge clk) begin
      chk("dig", {29'd0, bus.dig_n}, {29'd0, exp_dig});
      chk("seg", {24'd0, bus.seg_n}, {24'd0, exp_seg});
   end

   // wait for the start of the next active slot of digit d and check its segments
   task automatic wait_dig(input logic [2:0] d, input logic [7:0] s, input string tag);
      int n = 0;
      while (bus.dig_n == d && n < 200) begin
         @(negedge clk);
         n++;
      end
      while (bus.dig_n != d && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200)
         chk({tag, "_timeout"}, n, 0);
      else
         chk(tag, {24'd0, bus.seg_n}, {24'd0, s});
   endtask

   task automatic settle(input logic [11:0] b, input game_status_t g);
      bus.bcd_data = b;
      bus.game_status = g;
      repeat (2 * FRAME + 2) @(negedge clk);
   endtask

   initial begin
      int lit;
      bus.bcd_data = 12'h123;
      bus.game_status = PLAY;
      repeat (5) @(negedge clk);
      #1 chk("rst_dig", {29'd0, bus.dig_n}, 32'h7);
      chk("rst_seg", {24'd0, bus.seg_n}, 32'hFF);
      @(negedge clk);
      rst_n = 1'b1;
      wait_dig(3'b110, 8'hC0, "first_u0");
      wait_dig(3'b110, 8'hB0, "u3");
      wait_dig(3'b101, 8'hA4, "t2");
      wait_dig(3'b011, 8'hF9, "h1");

      settle(12'h042, PLAY);
      wait_dig(3'b110, 8'hA4, "b042_u");
      wait_dig(3'b101, 8'h99, "b042_t");
      settle(12'h005, START);
      wait_dig(3'b110, 8'h92, "b005_u");
      settle(12'h100, PLAY);
      wait_dig(3'b101, 8'hC0, "b100_t");
      wait_dig(3'b011, 8'hF9, "b100_h");

      settle(12'h011, PLAY);
      wait_dig(3'b101, 8'hF9, "tear_t1");
      bus.bcd_data = 12'h099;
      repeat (2) @(negedge clk);
      chk("tear_hold", {24'd0, bus.seg_n}, 32'hF9);
      wait_dig(3'b110, 8'h90, "tear_u9");
      wait_dig(3'b101, 8'h90, "tear_t9");

      settle(12'h0A3, PLAY);
      wait_dig(3'b101, 8'hBF, "dash_t");
      wait_dig(3'b110, 8'hB0, "dash_u");

      settle(12'h005, DIE);
      lit = 0;
      repeat (4 * FRAME) begin
         @(negedge clk);
         if (bus.dig_n == 3'b110)
            lit++;
      end
      chk("blink_duty", lit, 2 * (SD - DC));
      repeat (FRAME + 5) @(negedge clk);
      bus.game_status = PLAY;
      repeat (FRAME) @(negedge clk);
      bus.game_status = DIE;
      repeat (3 * FRAME) @(negedge clk);

      settle(12'h042, PLAY);
      wait_dig(3'b101, 8'h99, "pre_rst_t");
      #2 rst_n = 1'b0;
      #1 chk("arst_dig", {29'd0, bus.dig_n}, 32'h7);
      chk("arst_seg", {24'd0, bus.seg_n}, 32'hFF);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      wait_dig(3'b110, 8'hC0, "arst_u0");

      for (int i = 0; i < 40; i++) begin
         for (int k = 0; k < 3; k++)
            bus.bcd_data[k*4 +: 4] = $urandom_range(0, 2) == 0 ? 4'd0 : 4'($urandom_range(1, 11));
         bus.game_status = $urandom_range(0, 1) == 0 ? DIE : game_status_t'($urandom_range(0, 3));
         repeat ($urandom_range(1, 120)) @(negedge clk);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
